// File: rtl/prog_seq_cntr_pkg.sv
// prog_seq_cntr_pkg
// Shared constants and index helpers for the programmable sequence counter.
//   DIR_FWD / DIR_REV : encodings of the dir input
//   next_idx()        : one step forward or backward through the table, with wrap
//   clamp_idx()       : limits an externally supplied index to the table range
package prog_seq_cntr_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic int next_idx(input int cur, input logic dir, input int depth);
        if (dir == DIR_FWD) begin
            return (cur >= depth - 1) ? 0 : cur + 1;
        end
        return (cur == 0) ? depth - 1 : cur - 1;
    endfunction

    function automatic int clamp_idx(input int i, input int depth);
        return (i >= depth) ? depth - 1 : i;
    endfunction

endpackage

// File: rtl/prog_seq_cntr_if.sv
// prog_seq_cntr_if
// Control and status bundle of the sequence counter.
//   master : drives en, dir, one_shot, load, load_idx (and wr_* with
//            PROG_SEQ_CNTR_WRITE_EN); observes q, idx, tc, done
//   slave  : the counter itself
interface prog_seq_cntr_if #(
    parameter int WIDTH = 3,
    parameter int IDXW  = 3
);
    logic             en;
    logic             dir;
    logic             one_shot;
    logic             load;
    logic [IDXW-1:0]  load_idx;
`ifdef PROG_SEQ_CNTR_WRITE_EN
    logic             wr_en;
    logic [IDXW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_data;
`endif
    logic [WIDTH-1:0] q;
    logic [IDXW-1:0]  idx;
    logic             tc;
    logic             done;

    modport master (
        output en, dir, one_shot, load, load_idx,
`ifdef PROG_SEQ_CNTR_WRITE_EN
        output wr_en, wr_idx, wr_data,
`endif
        input  q, idx, tc, done
    );

    modport slave (
        input  en, dir, one_shot, load, load_idx,
`ifdef PROG_SEQ_CNTR_WRITE_EN
        input  wr_en, wr_idx, wr_data,
`endif
        output q, idx, tc, done
    );
endinterface

// File: rtl/prog_seq_cntr_table.sv
// prog_seq_cntr_table
// Sequence table storage and read port.
// Macro PROG_SEQ_CNTR_WRITE_EN:
//   defined   : DEPTH x WIDTH register file, reloaded from INIT_SEQ on clear,
//               written via wr_en/wr_idx/wr_data; a write to the entry being
//               read is forwarded to rd_data in the same cycle
//   undefined : constant table decoded from INIT_SEQ, no clk/clear/wr ports
// Ports:
//   rd_idx  in  IDXW   entry to read (the counter's next index)
//   rd_data out WIDTH  code at rd_idx (combinational)
//   clk, clear, wr_en, wr_idx, wr_data  only with PROG_SEQ_CNTR_WRITE_EN
module prog_seq_cntr_table #(
    parameter int                       WIDTH    = 3,
    parameter int                       DEPTH    = 5,
    parameter int                       IDXW     = 3,
    parameter logic [WIDTH*DEPTH-1:0]   INIT_SEQ = '0
) (
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data
`ifdef PROG_SEQ_CNTR_WRITE_EN
    ,
    input  logic             clk,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic [WIDTH-1:0] wr_data
`endif
);

    logic [WIDTH-1:0] tbl [DEPTH];
    logic             rd_ok;

    assign rd_ok = int'(rd_idx) < DEPTH;

`ifdef PROG_SEQ_CNTR_WRITE_EN
    logic wr_ok;

    assign wr_ok = wr_en && (int'(wr_idx) < DEPTH);

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= INIT_SEQ[i*WIDTH +: WIDTH];
            end
        end else if (wr_ok) begin
            tbl[wr_idx] <= wr_data;
        end
    end

    // Forward a same-cycle write so q never shows the stale entry.
    always_comb begin
        rd_data = rd_ok ? tbl[rd_idx] : '0;
        if (wr_ok && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
        end
    end
`else
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign tbl[i] = INIT_SEQ[i*WIDTH +: WIDTH];
    end

    assign rd_data = rd_ok ? tbl[rd_idx] : '0;
`endif

endmodule

// File: rtl/prog_seq_cntr.sv
// prog_seq_cntr
// Programmable arbitrary-sequence counter: steps through DEPTH codes of WIDTH
// bits in table order, forward or reverse, wrapping or one-shot, with index
// preload. Entry 0 of INIT_SEQ sits in the LSBs.
// Optional macro PROG_SEQ_CNTR_WRITE_EN makes the table writable (wr_* on bus).
// Ports:
//   clk    in   rising-edge clock
//   clear  in   synchronous active-high reset (idx=0, q=table[0], done=0)
//   bus    slave modport of prog_seq_cntr_if:
//          en, dir, one_shot, load, load_idx [, wr_en, wr_idx, wr_data] in
//          q, idx, done (registered), tc (combinational) out
// Priority per edge: clear > load > en.
module prog_seq_cntr
    import prog_seq_cntr_pkg::*;
#(
    parameter int                       WIDTH    = 3,
    parameter int                       DEPTH    = 5,
    parameter int                       IDXW     = $clog2(DEPTH),
    parameter logic [WIDTH*DEPTH-1:0]   INIT_SEQ = {3'd1, 3'd5, 3'd0, 3'd7, 3'd4}
) (
    input  logic            clk,
    input  logic            clear,
    prog_seq_cntr_if.slave  bus
);

    localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

    logic [IDXW-1:0]  idx_r;
    logic [IDXW-1:0]  nidx;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rd_data;
    logic             done_r;
    logic             ndone;
    logic             at_term;

    // Terminal index follows the live dir so a direction change takes effect
    // on the very next step.
    assign at_term = (bus.dir == DIR_FWD) ? (idx_r == LAST) : (idx_r == '0);
    assign bus.tc  = bus.en & ~done_r & at_term;

    always_comb begin
        nidx  = idx_r;
        ndone = done_r;
        if (bus.load) begin
            nidx  = IDXW'(clamp_idx(int'(bus.load_idx), DEPTH));
            ndone = 1'b0;
        end else if (bus.en && !done_r) begin
            if (at_term && bus.one_shot) begin
                ndone = 1'b1;
            end else begin
                nidx = IDXW'(next_idx(int'(idx_r), bus.dir, DEPTH));
            end
        end
    end

    // The table is read at the next index, so q and idx move together.
    prog_seq_cntr_table #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .IDXW     (IDXW),
        .INIT_SEQ (INIT_SEQ)
    ) u_table (
        .rd_idx  (nidx),
        .rd_data (rd_data)
`ifdef PROG_SEQ_CNTR_WRITE_EN
        ,
        .clk     (clk),
        .clear   (clear),
        .wr_en   (bus.wr_en),
        .wr_idx  (bus.wr_idx),
        .wr_data (bus.wr_data)
`endif
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            idx_r  <= '0;
            q_r    <= INIT_SEQ[WIDTH-1:0];
            done_r <= 1'b0;
        end else begin
            idx_r  <= nidx;
            q_r    <= rd_data;
            done_r <= ndone;
        end
    end

    assign bus.q    = q_r;
    assign bus.idx  = idx_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_prog_seq_cntr.sv
// tb_prog_seq_cntr
// Self-checking bench for prog_seq_cntr with default parameters (sequence
// 4,7,0,5,1). Directed vector table plus a randomized run against a small
// behavioural model; table-write cases only when PROG_SEQ_CNTR_WRITE_EN is set.
module tb_prog_seq_cntr;

    localparam int WIDTH = 3;
    localparam int DEPTH = 5;
    localparam int IDXW  = 3;

    typedef struct {
        bit clr, en, dir, os, ld;
        int ld_idx;
        bit wr_en;
        int wr_idx, wr_data;
        int e_tc, e_idx, e_q, e_done;   // e_idx < 0: compare with the model
    } vec_t;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    prog_seq_cntr_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

    prog_seq_cntr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int init_codes [DEPTH] = '{4, 7, 0, 5, 1};
    int m_tbl [DEPTH];
    int m_idx  = 0;
    bit m_done = 1'b0;
    int m_tc;
    logic got_tc;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit clr, bit en, bit dir, bit os, bit ld, int ld_idx,
                                int e_tc, int e_idx, int e_q, int e_done);
        vec_t v;
        v.clr = clr; v.en = en; v.dir = dir; v.os = os; v.ld = ld; v.ld_idx = ld_idx;
        v.wr_en = 1'b0; v.wr_idx = 0; v.wr_data = 0;
        v.e_tc = e_tc; v.e_idx = e_idx; v.e_q = e_q; v.e_done = e_done;
        return v;
    endfunction

    function automatic vec_t mkw(bit clr, bit en, int wr_idx, int wr_data,
                                 int e_tc, int e_idx, int e_q, int e_done);
        vec_t v;
        v = mk(clr, en, 1'b0, 1'b0, 1'b0, 0, e_tc, e_idx, e_q, e_done);
        v.wr_en = 1'b1; v.wr_idx = wr_idx; v.wr_data = wr_data;
        return v;
    endfunction

    function automatic bit at_end(bit dir, int i);
        return dir ? (i == 0) : (i == DEPTH - 1);
    endfunction

    // Drive one cycle: sample tc before the edge, advance the model at the edge,
    // leave outputs settled 1 time unit after it.
    task automatic apply(input vec_t v);
        clear        = v.clr;
        bus.en       = v.en;
        bus.dir      = v.dir;
        bus.one_shot = v.os;
        bus.load     = v.ld;
        bus.load_idx = IDXW'(v.ld_idx);
`ifdef PROG_SEQ_CNTR_WRITE_EN
        bus.wr_en    = v.wr_en;
        bus.wr_idx   = IDXW'(v.wr_idx);
        bus.wr_data  = WIDTH'(v.wr_data);
`endif
        #2;
        got_tc = bus.tc;
        m_tc   = (v.en && !m_done && at_end(v.dir, m_idx)) ? 1 : 0;
        @(posedge clk);
        if (v.clr) begin
            m_idx  = 0;
            m_done = 1'b0;
            m_tbl  = init_codes;
        end else begin
`ifdef PROG_SEQ_CNTR_WRITE_EN
            if (v.wr_en && v.wr_idx < DEPTH) m_tbl[v.wr_idx] = v.wr_data;
`endif
            if (v.ld) begin
                m_idx  = (v.ld_idx < DEPTH) ? v.ld_idx : DEPTH - 1;
                m_done = 1'b0;
            end else if (v.en && !m_done) begin
                if (v.os && at_end(v.dir, m_idx)) m_done = 1'b1;
                else m_idx = v.dir ? (m_idx + DEPTH - 1) % DEPTH : (m_idx + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".tc"},   got_tc,   m_tc);
        chk({tag, ".idx"},  bus.idx,  m_idx);
        chk({tag, ".q"},    bus.q,    m_tbl[m_idx]);
        chk({tag, ".done"}, bus.done, m_done);
    endtask

    initial begin
        vec_t r;
        m_tbl = init_codes;

        //                clr en dir os ld ldi   tc idx q done
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 4, 0));  // reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 1, 7, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 3, 5, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 4, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      1, 0, 4, 0));  // forward wrap
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,      1, 4, 1, 0));  // reverse wrap
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,      0, 3, 5, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,      0, 4, 1, 0));  // one-shot
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,      1, 4, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,      0, 4, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,      0, 4, 1, 1));  // dir flip keeps done
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,      0, 4, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,      0, 1, 7, 0));  // load releases done
        vecs.push_back(mk(0, 1, 0, 0, 1, 2,      0, 2, 0, 0));  // load beats en
        vecs.push_back(mk(1, 1, 0, 0, 1, 3,      0, 0, 4, 0));  // clear beats load
        vecs.push_back(mk(0, 0, 0, 0, 1, 7,      0, 4, 1, 0));  // clamp
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0, 4, 1, 0));  // hold
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,      0, 1, 7, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,      0, 0, 4, 0));  // reverse one-shot
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,      1, 0, 4, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0,      0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 1, 7, 0));
`ifdef PROG_SEQ_CNTR_WRITE_EN
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 4, 0));
        vecs.push_back(mkw(0, 1, 1, 3,           0, 1, 3, 0));  // forward to next idx
        vecs.push_back(mkw(0, 0, 1, 6,           0, 1, 6, 0));  // held idx
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 1, 7, 0));  // entry 1 restored
        vecs.push_back(mkw(0, 0, 5, 2,           0, 1, 7, 0));  // out of range
        vecs.push_back(mkw(0, 0, 7, 6,           0, 1, 7, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 3, 5, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 4, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      1, 0, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 1, 7, 0));
        vecs.push_back(mkw(0, 1, 3, 2,           0, 2, 0, 0));  // write ahead while stepping
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,      0, 3, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 4, 0));
`endif

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(vecs[i]);
            chk({tag, ".tc"},   got_tc,   vecs[i].e_tc);
            chk({tag, ".idx"},  bus.idx,  vecs[i].e_idx);
            chk({tag, ".q"},    bus.q,    vecs[i].e_q);
            chk({tag, ".done"}, bus.done, vecs[i].e_done);
        end

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            r = mk($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                   1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 7), 0, -1, 0, 0);
            r.wr_en   = $urandom_range(0, 4) == 0;
            r.wr_idx  = $urandom_range(0, 7);
            r.wr_data = $urandom_range(0, 7);
            apply(r);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
